// File: rtl/countdown_timer_32bit_pkg.sv
// rtl/countdown_timer_32bit_pkg.sv - shared state encoding and width defaults for the timer family
package countdown_timer_32bit_pkg;

    localparam int DEFAULT_WIDTH     = 32;
    localparam int DEFAULT_OFF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Total decrement for one RUN cycle: the base tick plus an optional offset.
    function automatic logic [DEFAULT_WIDTH-1:0] calc_dec(
        input logic                         sub_en,
        input logic [DEFAULT_OFF_WIDTH-1:0] off
    );
        calc_dec = DEFAULT_WIDTH'(1) + (sub_en ? DEFAULT_WIDTH'(off) : '0);
    endfunction

endpackage

// File: rtl/countdown_timer_32bit_sat_decrement.sv
// rtl/countdown_timer_32bit_sat_decrement.sv - saturating subtract of dec from count, with zero flags
module countdown_timer_32bit_sat_decrement #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic [WIDTH-1:0] dec_i,
    output logic [WIDTH-1:0] next_o,
    output logic             next_zero_o,
    output logic             count_zero_o
);

    logic [WIDTH:0] count_ext;
    logic [WIDTH:0] dec_ext;
    logic           underflow;

    // Compare one bit wider so a large dec can never alias to a small one.
    assign count_ext    = {1'b0, count_i};
    assign dec_ext      = {1'b0, dec_i};
    assign underflow    = (count_ext <= dec_ext);
    assign next_o       = underflow ? '0 : (count_i - dec_i);
    assign next_zero_o  = (next_o == '0);
    assign count_zero_o = (count_i == '0);

endmodule

// File: rtl/countdown_timer_32bit.sv
// rtl/countdown_timer_32bit.sv - loadable saturating down-counter with expiry pulse and optional auto-reload
module countdown_timer_32bit
    import countdown_timer_32bit_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int OFF_WIDTH   = DEFAULT_OFF_WIDTH,
    parameter int AUTO_RELOAD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [WIDTH-1:0]     loadVal,
    input  logic                 start,
    input  logic                 halt,
    input  logic                 subStart,
    input  logic [OFF_WIDTH-1:0] para,
    output logic [WIDTH-1:0]     count,
    output logic                 zero,
    output logic                 expired,
    output logic                 busy
);

    localparam bit AR_EN = (AUTO_RELOAD != 0);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             expired_q, expired_d;
    logic             busy_q;

    logic [WIDTH-1:0] dec_w;
    logic [WIDTH-1:0] next_w;
    logic             next_zero_w;
    logic             count_zero_w;

    assign dec_w = WIDTH'(1) + (subStart ? {{(WIDTH-OFF_WIDTH){1'b0}}, para} : '0);

    countdown_timer_32bit_sat_decrement #(
        .WIDTH(WIDTH)
    ) u_sat_dec (
        .count_i      (count_q),
        .dec_i        (dec_w),
        .next_o       (next_w),
        .next_zero_o  (next_zero_w),
        .count_zero_o (count_zero_w)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        expired_d = 1'b0;
        if (load) begin
            count_d  = loadVal;
            reload_d = loadVal;
            state_d  = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start && !count_zero_w) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (halt) begin
                        state_d = ST_IDLE;
                    end else if (count_zero_w) begin
                        // Reload cycle of auto-reload mode: this cycle is the "+1" of the period.
                        if (reload_q == '0) begin
                            state_d = ST_IDLE;
                        end else begin
                            count_d = reload_q;
                        end
                    end else begin
                        count_d = next_w;
                        if (next_zero_w) begin
                            expired_d = 1'b1;
                            if (!AR_EN) begin
                                state_d = ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            expired_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            expired_q <= expired_d;
            busy_q    <= (state_d == ST_RUN);
        end
    end

    assign count   = count_q;
    assign zero    = count_zero_w;
    assign expired = expired_q;
    assign busy    = busy_q;

endmodule
